// File: rtl/axis_width_serializer.sv
// AXI-Stream width down-converter: buffers IN_W-bit words in a small FIFO and
// emits them as OUT_W-bit slices, skipping slices whose keep bit is clear.
module axis_width_serializer #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_reset,
  input  logic [IN_W-1:0]        m_axis_tdata,
  input  logic [IN_W/OUT_W-1:0]  m_axis_tkeep,
  input  logic                   m_axis_tlast,
  input  logic                   m_axis_valid,
  output logic                   m_axis_ready,
  output logic [OUT_W-1:0]       o_tdata,
  output logic                   o_tlast,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_err_null_last
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SEL_W = $clog2(RATIO);

  // Input FIFO storage and bookkeeping
  logic [IN_W-1:0]  mem_data [DEPTH];
  logic [RATIO-1:0] mem_keep [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             wr_en, rd_en, fifo_empty;

  // Unpacker state
  logic [IN_W-1:0]  word_q;
  logic [RATIO-1:0] mask_q;
  logic             last_q;
  logic             err_q;

  logic [SEL_W-1:0] sel;
  logic [RATIO-1:0] sel_mask;
  logic [RATIO-1:0] mask_left;
  logic             fire;

  assign wr_en      = m_axis_valid && ready_q;
  assign fifo_empty = (count_q == '0);
  assign count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

  // Ready is a register so downstream stalls never reach the input port combinationally
  assign m_axis_ready = ready_q;

  // Pick the next slice to emit from the remaining-keep mask
  always_comb begin
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(RATIO); i++) begin
        if (mask_q[i]) sel = SEL_W'(i);
      end
    end else begin
      for (int i = int'(RATIO) - 1; i >= 0; i--) begin
        if (mask_q[i]) sel = SEL_W'(i);
      end
    end
  end

  assign sel_mask  = RATIO'(1) << sel;
  assign o_valid   = |mask_q;
  assign fire      = o_valid && i_ready;
  assign mask_left = fire ? (mask_q & ~sel_mask) : mask_q;
  // Pop when the current word is (or is about to be) exhausted, giving zero-bubble reloads
  assign rd_en     = (mask_left == '0) && !fifo_empty;

  assign o_tdata         = word_q[int'(sel) * OUT_W +: OUT_W];
  assign o_tlast         = last_q && $onehot(mask_q);
  assign o_err_null_last = err_q;

  // FIFO storage writes; contents need no reset since pointers qualify them
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= m_axis_tdata;
      mem_keep[wr_ptr_q] <= m_axis_tkeep;
      mem_last[wr_ptr_q] <= m_axis_tlast;
    end
  end

  // FIFO pointers, occupancy and registered input ready
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Unpacker: load a new word on pop, otherwise retire emitted slices
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_reset) begin
      word_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (rd_en) begin
      word_q <= mem_data[rd_ptr_q];
      mask_q <= mem_keep[rd_ptr_q];
      last_q <= mem_last[rd_ptr_q];
      // A null word carrying tlast loses its packet boundary; flag it
      if ((mem_keep[rd_ptr_q] == '0) && mem_last[rd_ptr_q]) err_q <= 1'b1;
    end else begin
      mask_q <= mask_left;
    end
  end

endmodule
